// File: rtl/prefix_scan_ctrl_pkg.sv
// Shared definitions for the x86 legacy-prefix scanner: prefix byte values,
// FSM state encoding and the registered summary record.
package prefix_scan_ctrl_pkg;

  localparam logic [7:0] PFX_REP  = 8'hF3;
  localparam logic [7:0] PFX_CS   = 8'h2E;
  localparam logic [7:0] PFX_SS   = 8'h36;
  localparam logic [7:0] PFX_DS   = 8'h3E;
  localparam logic [7:0] PFX_ES   = 8'h26;
  localparam logic [7:0] PFX_FS   = 8'h64;
  localparam logic [7:0] PFX_GS   = 8'h65;
  localparam logic [7:0] PFX_OPSZ = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       rep;
    logic [5:0] seg;
    logic       opsz;
    logic [1:0] len;
    logic [7:0] opcode;
    logic       err;
  } summary_t;

endpackage

// File: rtl/prefix_cmp.sv
// Classifies one byte as a legacy prefix and reports which flag it carries.
module prefix_cmp
  import prefix_scan_ctrl_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_prefix,
  output logic       is_rep,
  output logic       is_opsz,
  output logic [5:0] seg_onehot
);

  always_comb begin
    is_rep     = 1'b0;
    is_opsz    = 1'b0;
    seg_onehot = 6'b000000;
    case (byte_in)
      PFX_REP:  is_rep     = 1'b1;
      PFX_OPSZ: is_opsz    = 1'b1;
      PFX_CS:   seg_onehot = 6'b000001;
      PFX_SS:   seg_onehot = 6'b000010;
      PFX_DS:   seg_onehot = 6'b000100;
      PFX_ES:   seg_onehot = 6'b001000;
      PFX_FS:   seg_onehot = 6'b010000;
      PFX_GS:   seg_onehot = 6'b100000;
      default:  ;
    endcase
    is_prefix = is_rep | is_opsz | (|seg_onehot);
  end

endmodule

// File: rtl/prefix_scan_ctrl.sv
// Scans up to three legacy prefixes in a 4-byte instruction window, one byte
// per cycle, and presents a summary until the consumer accepts it.
//
// state | meaning
// IDLE  | waiting for a window, in_ready = 1
// SCAN  | classifying byte[idx] each cycle
// DONE  | summary valid, held until out_ready or flush
module prefix_scan_ctrl
  import prefix_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        is_rep,
  output logic [5:0]  seg_override,
  output logic        is_opsize_override,
  output logic [1:0]  prefix_len,
  output logic [7:0]  opcode_byte,
  output logic        prefix_err
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] win_q, win_d;
  logic       rep_acc_q, rep_acc_d;
  logic       opsz_acc_q, opsz_acc_d;
  logic [5:0] seg_acc_q, seg_acc_d;
  summary_t   sum_q, sum_d;

  logic [7:0] cur_byte;
  logic       cmp_prefix, cmp_rep, cmp_opsz;
  logic [5:0] cmp_seg;

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = win_q[7:0];
      2'd1:    cur_byte = win_q[15:8];
      2'd2:    cur_byte = win_q[23:16];
      default: cur_byte = win_q[31:24];
    endcase
  end

  prefix_cmp u_cmp (
    .byte_in    (cur_byte),
    .is_prefix  (cmp_prefix),
    .is_rep     (cmp_rep),
    .is_opsz    (cmp_opsz),
    .seg_onehot (cmp_seg)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    win_d      = win_q;
    rep_acc_d  = rep_acc_q;
    opsz_acc_d = opsz_acc_q;
    seg_acc_d  = seg_acc_q;
    sum_d      = sum_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          win_d      = in_bytes;
          idx_d      = 2'd0;
          rep_acc_d  = 1'b0;
          opsz_acc_d = 1'b0;
          seg_acc_d  = 6'b000000;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        sum_d.rep  = rep_acc_q;
        sum_d.seg  = seg_acc_q;
        sum_d.opsz = opsz_acc_q;
        if (cmp_prefix && idx_q != 2'd3) begin
          rep_acc_d  = rep_acc_q | cmp_rep;
          opsz_acc_d = opsz_acc_q | cmp_opsz;
          if (|cmp_seg) seg_acc_d = cmp_seg;
          idx_d      = idx_q + 2'd1;
          sum_d      = sum_q;
        end else if (cmp_prefix) begin
          // a fourth prefix has no opcode byte left in the window
          sum_d.err    = 1'b1;
          sum_d.opcode = 8'h00;
          sum_d.len    = 2'd3;
          state_d      = ST_DONE;
        end else begin
          sum_d.err    = 1'b0;
          sum_d.opcode = cur_byte;
          sum_d.len    = idx_q;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          sum_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d    = ST_IDLE;
      idx_d      = 2'd0;
      rep_acc_d  = 1'b0;
      opsz_acc_d = 1'b0;
      seg_acc_d  = 6'b000000;
      sum_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      win_q      <= 32'h0;
      rep_acc_q  <= 1'b0;
      opsz_acc_q <= 1'b0;
      seg_acc_q  <= 6'b000000;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      rep_acc_q  <= rep_acc_d;
      opsz_acc_q <= opsz_acc_d;
      seg_acc_q  <= seg_acc_d;
      sum_q      <= sum_d;
    end
  end

  assign in_ready           = (state_q == ST_IDLE);
  assign out_valid          = (state_q == ST_DONE);
  assign is_rep             = sum_q.rep;
  assign seg_override       = sum_q.seg;
  assign is_opsize_override = sum_q.opsz;
  assign prefix_len         = sum_q.len;
  assign opcode_byte        = sum_q.opcode;
  assign prefix_err         = sum_q.err;

endmodule

// File: tb/tb_prefix_scan_ctrl.sv
// Directed vector bench for prefix_scan_ctrl with hand-computed summaries.
module tb_prefix_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_bytes = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        is_rep;
  logic [5:0]  seg_override;
  logic        is_opsize_override;
  logic [1:0]  prefix_len;
  logic [7:0]  opcode_byte;
  logic        prefix_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prefix_scan_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_bytes           (in_bytes),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .is_rep             (is_rep),
    .seg_override       (seg_override),
    .is_opsize_override (is_opsize_override),
    .prefix_len         (prefix_len),
    .opcode_byte        (opcode_byte),
    .prefix_err         (prefix_err)
  );

  typedef struct {
    logic [31:0] bytes;
    int          lat;
    logic        rep;
    logic [5:0]  seg;
    logic        opsz;
    logic [1:0]  len;
    logic [7:0]  op;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_summary(input string tag, input vec_t v);
    chk({tag, " is_rep"}, 32'(is_rep), 32'(v.rep));
    chk({tag, " seg"}, 32'(seg_override), 32'(v.seg));
    chk({tag, " opsz"}, 32'(is_opsize_override), 32'(v.opsz));
    chk({tag, " len"}, 32'(prefix_len), 32'(v.len));
    chk({tag, " opcode"}, 32'(opcode_byte), 32'(v.op));
    chk({tag, " err"}, 32'(prefix_err), 32'(v.err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outputs zero"},
        {17'h0, out_valid, is_rep, seg_override, is_opsize_override, prefix_len, opcode_byte, prefix_err},
        32'h0);
  endtask

  // Accepts a window, returns the number of edges from accept to out_valid.
  task automatic send_and_wait(input logic [31:0] b, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_bytes = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd1);
    chk_all_zero({tag, " after accept"});
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    send_and_wait(v.bytes, lat);
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " in_ready low"}, 32'(in_ready), 32'd0);
    chk_summary(tag, v);
    handshake(tag);
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h0000_0090, 1, 1'b0, 6'b000000, 1'b0, 2'd0, 8'h90, 1'b0};
    vecs[1] = '{32'h00A5_66F3, 3, 1'b1, 6'b000000, 1'b1, 2'd2, 8'hA5, 1'b0};
    vecs[2] = '{32'h0089_642E, 3, 1'b0, 6'b010000, 1'b0, 2'd2, 8'h89, 1'b0};
    vecs[3] = '{32'h66F3_2E66, 4, 1'b1, 6'b000001, 1'b1, 2'd3, 8'h00, 1'b1};
    vecs[4] = '{32'hC3F3_F3F3, 4, 1'b1, 6'b000000, 1'b0, 2'd3, 8'hC3, 1'b0};
    vecs[5] = '{32'h0000_0036, 2, 1'b0, 6'b000010, 1'b0, 2'd1, 8'h00, 1'b0};
    vecs[6] = '{32'h0000_3E26, 3, 1'b0, 6'b000100, 1'b0, 2'd2, 8'h00, 1'b0};
    vecs[7] = '{32'h6566_6590, 1, 1'b0, 6'b000000, 1'b0, 2'd0, 8'h90, 1'b0};

    #12;
    chk_all_zero("in reset");
    chk("in_ready in reset", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // consumer stall: summary must hold for five cycles
    send_and_wait(vecs[1].bytes, lat);
    chk("stall latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall c%0d valid", c), 32'(out_valid), 32'd1);
      chk_summary($sformatf("stall c%0d", c), vecs[1]);
      @(posedge clk);
      #1;
    end
    handshake("stall");

    // flush during the second SCAN cycle
    @(negedge clk);
    in_valid = 1'b1;
    in_bytes = vecs[2].bytes;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_all_zero("scan summary hidden");
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk_all_zero($sformatf("post-flush c%0d", c));
      @(posedge clk);
      #1;
    end
    run_vec("after flush", vecs[0]);

    // reset mid-SCAN
    @(negedge clk);
    in_valid = 1'b1;
    in_bytes = vecs[3].bytes;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid-scan reset");
    chk("mid-scan reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk_all_zero($sformatf("post-reset c%0d", c));
    end
    run_vec("after reset", vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
